// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32 decode stage with a registered ID/EX boundary,
// valid/ready handshakes on both sides, load-use bubble insertion and flush.
module id_stage_pipe #(
    parameter int         XLEN          = 32,
    parameter int         NUM_CUSTOM    = 4,
    parameter logic [6:0] CUSTOM_OPCODE = 7'b0001011,
    parameter bit         HAZARD_EN     = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1_idx,
    output logic [4:0]      out_rs2_idx,
    output logic [4:0]      out_rd_idx,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_use_imm,
    output logic            out_branch,
    output logic            out_jal,
    output logic            out_illegal,
    output logic [3:0]      out_alu_ctrl
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_idx;
        logic [4:0]      rs2_idx;
        logic [4:0]      rd_idx;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            use_imm;
        logic            branch;
        logic            jal;
        logic            illegal;
        logic [3:0]      alu_ctrl;
    } idex_t;

    idex_t idex_q, idex_d;
    logic  valid_q, valid_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        custom_legal;

    logic [31:0] imm32;
    logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_use_imm;
    logic        dec_branch, dec_jal, dec_illegal;
    logic [3:0]  dec_alu_ctrl;
    logic        use_rs1, use_rs2;

    logic        hazard, advance, load;

    assign opcode   = instr_in[6:0];
    assign rd       = instr_in[11:7];
    assign funct3   = instr_in[14:12];
    assign funct7   = instr_in[31:25];
    assign rs1_addr = instr_in[19:15];
    assign rs2_addr = instr_in[24:20];

    assign custom_legal = ({1'b0, funct3} < 4'(NUM_CUSTOM));

    // Combinational decode of the presented instruction word.
    always_comb begin
        imm32         = '0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_use_imm   = 1'b0;
        dec_branch    = 1'b0;
        dec_jal       = 1'b0;
        dec_illegal   = 1'b0;
        dec_alu_ctrl  = 4'd0;
        use_rs1       = 1'b0;
        use_rs2       = 1'b0;
        case (opcode)
            OP_R: begin
                dec_reg_write = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                case (funct3)
                    3'b000:  dec_alu_ctrl = (funct7 == 7'b0100000) ? 4'd1 : 4'd0;
                    3'b111:  dec_alu_ctrl = 4'd2;
                    3'b110:  dec_alu_ctrl = 4'd3;
                    3'b100:  dec_alu_ctrl = 4'd4;
                    default: dec_alu_ctrl = 4'd0;
                endcase
            end
            OP_I: begin
                dec_reg_write = 1'b1;
                dec_use_imm   = 1'b1;
                use_rs1       = 1'b1;
                imm32         = {{20{instr_in[31]}}, instr_in[31:20]};
            end
            OP_LOAD: begin
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                dec_use_imm   = 1'b1;
                use_rs1       = 1'b1;
                imm32         = {{20{instr_in[31]}}, instr_in[31:20]};
            end
            OP_STORE: begin
                dec_mem_write = 1'b1;
                dec_use_imm   = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                imm32         = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            end
            OP_BRANCH: begin
                dec_branch    = 1'b1;
                dec_alu_ctrl  = 4'd1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                imm32         = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                                 instr_in[30:25], instr_in[11:8], 1'b0};
            end
            OP_JAL: begin
                dec_jal       = 1'b1;
                dec_reg_write = 1'b1;
                imm32         = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                                 instr_in[20], instr_in[30:21], 1'b0};
            end
            default: begin
                if (opcode == CUSTOM_OPCODE && custom_legal) begin
                    dec_reg_write = 1'b1;
                    dec_alu_ctrl  = 4'd8 + {1'b0, funct3};
                    use_rs1       = 1'b1;
                    use_rs2       = 1'b1;
                end else begin
                    dec_illegal   = 1'b1;
                end
            end
        endcase
        if (rd == 5'd0) begin
            dec_reg_write = 1'b0;
        end
    end

    // Load-use detection against the load currently held in the ID/EX register.
    always_comb begin
        hazard = HAZARD_EN && valid_q && idex_q.mem_read && (idex_q.rd_idx != 5'd0) && in_valid &&
                 ((use_rs1 && idex_q.rd_idx == rs1_addr) || (use_rs2 && idex_q.rd_idx == rs2_addr));
    end

    // Handshake and next-state selection for the ID/EX register; flush wins over load and hold.
    always_comb begin
        advance  = !valid_q || out_ready;
        in_ready = flush || (advance && !hazard);
        load     = in_valid && in_ready && !flush;
        valid_d  = valid_q;
        idex_d   = idex_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d          = 1'b1;
            idex_d.pc        = pc_in;
            idex_d.rs1_val   = rs1_data;
            idex_d.rs2_val   = rs2_data;
            idex_d.imm       = XLEN'($signed(imm32));
            idex_d.rs1_idx   = rs1_addr;
            idex_d.rs2_idx   = rs2_addr;
            idex_d.rd_idx    = rd;
            idex_d.reg_write = dec_reg_write;
            idex_d.mem_read  = dec_mem_read;
            idex_d.mem_write = dec_mem_write;
            idex_d.use_imm   = dec_use_imm;
            idex_d.branch    = dec_branch;
            idex_d.jal       = dec_jal;
            idex_d.illegal   = dec_illegal;
            idex_d.alu_ctrl  = dec_alu_ctrl;
        end else if (advance) begin
            valid_d = 1'b0;
        end
    end

    // ID/EX pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            idex_q  <= '0;
        end else begin
            valid_q <= valid_d;
            idex_q  <= idex_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = idex_q.pc;
    assign out_rs1_val   = idex_q.rs1_val;
    assign out_rs2_val   = idex_q.rs2_val;
    assign out_imm       = idex_q.imm;
    assign out_rs1_idx   = idex_q.rs1_idx;
    assign out_rs2_idx   = idex_q.rs2_idx;
    assign out_rd_idx    = idex_q.rd_idx;
    assign out_reg_write = idex_q.reg_write;
    assign out_mem_read  = idex_q.mem_read;
    assign out_mem_write = idex_q.mem_write;
    assign out_use_imm   = idex_q.use_imm;
    assign out_branch    = idex_q.branch;
    assign out_jal       = idex_q.jal;
    assign out_illegal   = idex_q.illegal;
    assign out_alu_ctrl  = idex_q.alu_ctrl;

endmodule
